// File: rtl/tt_ternary_pkg.sv
// Shared definitions for ternary weight sources and consumers.
// Weight codes, loader state encoding and default matrix shape.
package tt_ternary_pkg;

    localparam logic [1:0] W_ZERO    = 2'b00;
    localparam logic [1:0] W_POS     = 2'b01;
    localparam logic [1:0] W_NEG     = 2'b11;
    localparam logic [1:0] W_ILLEGAL = 2'b10;

    localparam int DEF_IN_LEN  = 16;
    localparam int DEF_OUT_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT_WAIT
    } state_e;

endpackage

// File: rtl/tt_ternary_unpack4.sv
// Splits one byte into four sanitised ternary codes.
// Illegal codes become zero and raise the illegal flag.
module tt_ternary_unpack4
    import tt_ternary_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] codes,
    output logic       illegal
);

    // Per-field sanitise: 2'b10 maps to zero weight.
    always_comb begin
        codes   = '0;
        illegal = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (in_byte[2*j +: 2] == W_ILLEGAL) begin
                codes[2*j +: 2] = W_ZERO;
                illegal         = 1'b1;
            end else begin
                codes[2*j +: 2] = in_byte[2*j +: 2];
            end
        end
    end

endmodule

// File: rtl/tt_ternary_weight_loader.sv
// Streams packed ternary bytes into a shadow bank, then commits
// it to the active bank once the multiplier is not mid-pass.
module tt_ternary_weight_loader
    import tt_ternary_pkg::*;
#(
    parameter int InLen  = DEF_IN_LEN,
    parameter int OutLen = DEF_OUT_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       consumer_busy,
    output logic [2*InLen*OutLen-1:0]  w_flat,
    output logic                       w_valid,
    output logic                       loading,
    output logic                       err
);

    localparam int NumBytes = InLen * OutLen / 4;
    localparam int NumW     = 2 * InLen * OutLen;
    localparam int CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumBytes - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [NumW-1:0]   shadow_q, shadow_d;
    logic [NumW-1:0]   active_q, active_d;
    logic              w_valid_q, w_valid_d;
    logic              err_q, err_d;
    logic [7:0]        codes;
    logic              illegal;

    tt_ternary_unpack4 u_unpack (
        .in_byte (in_data),
        .codes   (codes),
        .illegal (illegal)
    );

    assign in_ready = (state_q == LOAD);
    assign loading  = (state_q != IDLE);
    assign w_flat   = active_q;
    assign w_valid  = w_valid_q;
    assign err      = err_q;

    // Next state: load_start beats a same-cycle byte; the final
    // byte commits on its own edge when the consumer is idle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        w_valid_d = w_valid_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (in_valid) begin
                    shadow_d[{count_q, 3'b000} +: 8] = codes;
                    err_d = err_q | illegal;
                    if (count_q == LastCnt) begin
                        if (!consumer_busy) begin
                            active_d  = shadow_d;
                            w_valid_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            state_d = COMMIT_WAIT;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            COMMIT_WAIT: begin
                if (!consumer_busy) begin
                    active_d  = shadow_q;
                    w_valid_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears both banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            w_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            w_valid_q <= w_valid_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_tt_ternary_weight_loader.sv
// Directed bench for the ternary weight loader.
// Expected banks come from a byte-level reference model.
module tb_tt_ternary_weight_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_start;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         consumer_busy;
    logic [255:0] w_flat;
    logic         w_valid;
    logic         loading;
    logic         err;

    int total = 0;
    int bad   = 0;

    logic [7:0]   tb_bytes [32];
    logic [255:0] old_bank;

    tt_ternary_weight_loader #(.InLen(16), .OutLen(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .consumer_busy (consumer_busy),
        .w_flat        (w_flat),
        .w_valid       (w_valid),
        .loading       (loading),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_bank();
        logic [255:0] m;
        logic [7:0]   b;
        logic [1:0]   c;
        m = '0;
        for (int k = 0; k < 32; k++) begin
            b = tb_bytes[k];
            for (int j = 0; j < 4; j++) begin
                c = b[2*j +: 2];
                if (c == 2'b10) c = 2'b00;
                m[8*k + 2*j +: 2] = c;
            end
        end
        return m;
    endfunction

    function automatic logic model_err();
        logic e;
        logic [7:0] b;
        e = 1'b0;
        for (int k = 0; k < 32; k++) begin
            b = tb_bytes[k];
            for (int j = 0; j < 4; j++)
                if (b[2*j +: 2] == 2'b10) e = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic busy);
        in_valid      = 1'b1;
        in_data       = b;
        consumer_busy = busy;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send(tb_bytes[k], 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        load_start    = 1'b0;
        in_data       = 8'h00;
        in_valid      = 1'b0;
        consumer_busy = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_wflat", w_flat, '0);
        chk("rst_wvalid", w_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_loading", loading, 0);
        chk("rst_err", err, 0);

        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            chk("idle_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("idle_loading", loading, 0);
        chk("idle_wflat", w_flat, '0);

        // packing
        for (int k = 0; k < 32; k++) tb_bytes[k] = 8'h00;
        tb_bytes[0] = 8'h1D;
        start();
        chk("pk_ready", in_ready, 1);
        chk("pk_loading", loading, 1);
        send_range(0, 30);
        chk("pk_pre_wvalid", w_valid, 0);
        send(tb_bytes[31], 1'b0);
        chk("pk_wflat", w_flat, 256'h1D);
        chk("pk_wvalid", w_valid, 1);
        chk("pk_loading_end", loading, 0);
        chk("pk_ready_end", in_ready, 0);
        chk("pk_err", err, 0);
        old_bank = w_flat;

        // deferred commit
        for (int k = 0; k < 32; k++) tb_bytes[k] = 8'(k * 8'h25 + 8'h11);
        start();
        send_range(0, 30);
        send(tb_bytes[31], 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("dc_loading", loading, 1);
            chk("dc_ready", in_ready, 0);
            chk("dc_hold", w_flat, old_bank);
            load_start = (i == 2);
            tick();
            load_start = 1'b0;
        end
        consumer_busy = 1'b0;
        tick();
        chk("dc_wflat", w_flat, model_bank());
        chk("dc_loading_end", loading, 0);
        chk("dc_wvalid", w_valid, 1);
        chk("dc_err", err, model_err());

        // illegal code
        for (int k = 0; k < 32; k++) tb_bytes[k] = 8'h00;
        tb_bytes[5] = 8'h02;
        tb_bytes[6] = 8'h4D;
        start();
        send_range(0, 5);
        chk("il_err_mid", err, 1);
        send_range(6, 31);
        chk("il_err_after", err, 1);
        chk("il_w20", w_flat[41:40], 0);
        chk("il_wflat", w_flat, model_bank());
        old_bank = w_flat;
        start();
        chk("il_err_clr", err, 0);
        chk("il_loading", loading, 1);

        // restart with backpressure
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'(8'hA5 ^ i);
            tick();
        end
        in_valid = 1'b0;
        chk("rs_hold", w_flat, old_bank);
        chk("rs_wvalid", w_valid, 1);
        chk("rs_loading", loading, 1);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hAA;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        chk("rs_err_clr", err, 0);
        for (int k = 0; k < 32; k++) tb_bytes[k] = 8'(8'h5C ^ (k * 3));
        send_range(0, 30);
        chk("rs_still_loading", loading, 1);
        chk("rs_hold2", w_flat, old_bank);
        send(tb_bytes[31], 1'b0);
        chk("rs_wflat", w_flat, model_bank());
        chk("rs_err", err, model_err());

        // reset mid-load
        for (int k = 0; k < 32; k++) tb_bytes[k] = 8'(k + 1);
        start();
        send_range(0, 14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_wflat", w_flat, '0);
        chk("rm_wvalid", w_valid, 0);
        chk("rm_ready", in_ready, 0);
        chk("rm_loading", loading, 0);
        chk("rm_err", err, 0);
        for (int k = 0; k < 32; k++) tb_bytes[k] = 8'(8'hD1 - k);
        start();
        send_range(0, 31);
        chk("rm_reload", w_flat, model_bank());
        chk("rm_wvalid2", w_valid, 1);
        chk("rm_err2", err, model_err());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
